// File: rtl/exmem_pipe_reg.sv
// EX/MEM pipeline register with stall hold, flush-to-bubble and optional stall/bubble statistics.
// Define EXMEM_PIPE_STATS_EN to compile in the saturating stall_cnt_o/bubble_cnt_o counters.
module exmem_pipe_reg #(
   parameter int DATA_W = 32,
   parameter int NUM_CH = 4,
   parameter int RD_W   = 5,
   parameter int CNT_W  = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     stall_i,
   input  logic                     flush_i,
   input  logic                     valid_i,
   input  logic [DATA_W-1:0]        instr_i,
   input  logic                     regw_i,
   input  logic [RD_W-1:0]          rd_i,
   input  logic [NUM_CH*DATA_W-1:0] data_i,
`ifdef EXMEM_PIPE_STATS_EN
   output logic [CNT_W-1:0]         stall_cnt_o,
   output logic [CNT_W-1:0]         bubble_cnt_o,
`endif
   output logic                     valid_o,
   output logic [DATA_W-1:0]        instr_o,
   output logic                     regw_o,
   output logic [RD_W-1:0]          rd_o,
   output logic [NUM_CH*DATA_W-1:0] data_o
);

   logic                     valid_q, valid_d;
   logic [DATA_W-1:0]        instr_q, instr_d;
   logic                     regw_q, regw_d;
   logic [RD_W-1:0]          rd_q, rd_d;
   logic [NUM_CH*DATA_W-1:0] data_q, data_d;

   // Flush wins over stall; a flush leaves the payload lanes untouched since the bubble ignores them.
   always_comb begin
      valid_d = valid_q;
      instr_d = instr_q;
      regw_d  = regw_q;
      rd_d    = rd_q;
      data_d  = data_q;
      if (flush_i) begin
         valid_d = 1'b0;
         instr_d = '0;
         regw_d  = 1'b0;
         rd_d    = '0;
      end else if (!stall_i) begin
         valid_d = valid_i;
         instr_d = valid_i ? instr_i : '0;
         regw_d  = regw_i & valid_i;
         rd_d    = valid_i ? rd_i : '0;
         data_d  = data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= 1'b0;
         instr_q <= '0;
         regw_q  <= 1'b0;
         rd_q    <= '0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         instr_q <= instr_d;
         regw_q  <= regw_d;
         rd_q    <= rd_d;
         data_q  <= data_d;
      end
   end

   assign valid_o = valid_q;
   assign instr_o = instr_q;
   assign regw_o  = regw_q;
   assign rd_o    = rd_q;
   assign data_o  = data_q;

`ifdef EXMEM_PIPE_STATS_EN
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

   // A bubble is captured by any flush, or by a load of an invalid instruction; both counters saturate.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (stall_i && !flush_i && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      if ((flush_i || (!stall_i && !valid_i)) && (bubble_cnt_q != '1))
         bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign stall_cnt_o  = stall_cnt_q;
   assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_exmem_pipe_reg.sv
// Directed self-checking bench for exmem_pipe_reg; counter checks compile only with EXMEM_PIPE_STATS_EN.
module tb_exmem_pipe_reg;
   localparam int DATA_W = 32;
   localparam int NUM_CH = 4;
   localparam int RD_W   = 5;
   localparam int CNT_W  = 4;

   logic                     clk = 1'b0;
   logic                     reset;
   logic                     stall_i, flush_i, valid_i, regw_i;
   logic [DATA_W-1:0]        instr_i;
   logic [RD_W-1:0]          rd_i;
   logic [NUM_CH*DATA_W-1:0] data_i;
   logic                     valid_o, regw_o;
   logic [DATA_W-1:0]        instr_o;
   logic [RD_W-1:0]          rd_o;
   logic [NUM_CH*DATA_W-1:0] data_o;
`ifdef EXMEM_PIPE_STATS_EN
   logic [CNT_W-1:0]         stall_cnt_o, bubble_cnt_o;
   int                       expStall, expBubble;
`endif

   int checks = 0;
   int errors = 0;

   exmem_pipe_reg #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
      .valid_i(valid_i), .instr_i(instr_i), .regw_i(regw_i), .rd_i(rd_i), .data_i(data_i),
`ifdef EXMEM_PIPE_STATS_EN
      .stall_cnt_o(stall_cnt_o), .bubble_cnt_o(bubble_cnt_o),
`endif
      .valid_o(valid_o), .instr_o(instr_o), .regw_o(regw_o), .rd_o(rd_o), .data_o(data_o)
   );

   always #5 clk = ~clk;

   // Inputs change 1 ns after a rising edge; outputs are sampled 1 ns after the next one.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [DATA_W-1:0] ins, input logic rw,
                        input logic [RD_W-1:0] rd, input logic [NUM_CH*DATA_W-1:0] d);
      valid_i = v; instr_i = ins; regw_i = rw; rd_i = rd; data_i = d;
   endtask

   task automatic test_reset();
      reset = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
      drive(1'b1, 32'hFFFF_FFFF, 1'b1, 5'd31, {NUM_CH{32'hA5A5_A5A5}});
      tick();
      reset = 1'b0;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid got %0h want 0", valid_o); end
      checks++; if (instr_o !== '0) begin errors++; $display("[TB] FAIL reset_instr got %0h want 0", instr_o); end
      checks++; if (regw_o !== 1'b0) begin errors++; $display("[TB] FAIL reset_regw got %0h want 0", regw_o); end
      checks++; if (rd_o !== '0) begin errors++; $display("[TB] FAIL reset_rd got %0h want 0", rd_o); end
      checks++; if (data_o !== '0) begin errors++; $display("[TB] FAIL reset_data got %0h want 0", data_o); end
`ifdef EXMEM_PIPE_STATS_EN
      expStall = 0; expBubble = 0;
      checks++; if (stall_cnt_o !== 4'd0) begin errors++; $display("[TB] FAIL reset_stallcnt got %0d want 0", stall_cnt_o); end
      checks++; if (bubble_cnt_o !== 4'd0) begin errors++; $display("[TB] FAIL reset_bubblecnt got %0d want 0", bubble_cnt_o); end
`endif
   endtask

   task automatic test_load();
      logic [NUM_CH*DATA_W-1:0] d;
      d = {32'h4444_4444, 32'h0000_1000, 32'h2222_2222, 32'h1111_1111};
      drive(1'b1, 32'h8C01_0004, 1'b1, 5'd1, d);
      tick();
      checks++; if (valid_o !== 1'b1) begin errors++; $display("[TB] FAIL load_valid got %0h want 1", valid_o); end
      checks++; if (instr_o !== 32'h8C01_0004) begin errors++; $display("[TB] FAIL load_instr got %0h want 8c010004", instr_o); end
      checks++; if (regw_o !== 1'b1) begin errors++; $display("[TB] FAIL load_regw got %0h want 1", regw_o); end
      checks++; if (rd_o !== 5'd1) begin errors++; $display("[TB] FAIL load_rd got %0h want 1", rd_o); end
      checks++; if (data_o[2*DATA_W +: DATA_W] !== 32'h0000_1000) begin errors++; $display("[TB] FAIL load_lane2 got %0h want 1000", data_o[2*DATA_W +: DATA_W]); end
      checks++; if (data_o !== d) begin errors++; $display("[TB] FAIL load_lanes got %0h want %0h", data_o, d); end
   endtask

   task automatic test_stall();
      logic [NUM_CH*DATA_W-1:0] held, fresh;
      held  = {32'h4444_4444, 32'h0000_1000, 32'h2222_2222, 32'h1111_1111};
      fresh = {32'hDDDD_0003, 32'hCCCC_0002, 32'hBBBB_0001, 32'hAAAA_0000};
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(i[0], 32'h1000_0000 + i, 1'b0, 5'(i + 9), {NUM_CH{32'h0F0F_0000 + i}});
         tick();
         checks++;
         if (valid_o !== 1'b1 || instr_o !== 32'h8C01_0004 || regw_o !== 1'b1 || rd_o !== 5'd1 || data_o !== held) begin
            errors++;
            $display("[TB] FAIL stall_hold%0d got v%0h i%0h w%0h rd%0h d%0h want v1 i8c010004 w1 rd1 d%0h",
                     i, valid_o, instr_o, regw_o, rd_o, data_o, held);
         end
      end
`ifdef EXMEM_PIPE_STATS_EN
      expStall = 3;
      checks++; if (stall_cnt_o !== 4'(expStall)) begin errors++; $display("[TB] FAIL stall_cnt got %0d want %0d", stall_cnt_o, expStall); end
      checks++; if (bubble_cnt_o !== 4'(expBubble)) begin errors++; $display("[TB] FAIL stall_bubblecnt got %0d want %0d", bubble_cnt_o, expBubble); end
`endif
      stall_i = 1'b0;
      drive(1'b1, 32'hAC02_0008, 1'b0, 5'd2, fresh);
      tick();
      checks++;
      if (valid_o !== 1'b1 || instr_o !== 32'hAC02_0008 || regw_o !== 1'b0 || rd_o !== 5'd2 || data_o !== fresh) begin
         errors++;
         $display("[TB] FAIL stall_release got v%0h i%0h w%0h rd%0h d%0h want v1 iac020008 w0 rd2 d%0h",
                  valid_o, instr_o, regw_o, rd_o, data_o, fresh);
      end
   endtask

   task automatic test_flush_stall();
      logic [NUM_CH*DATA_W-1:0] d;
      d = {32'h0000_0004, 32'h0000_0003, 32'h0000_0002, 32'h0000_0001};
      drive(1'b1, 32'h0062_2020, 1'b1, 5'd4, d);
      tick();
      checks++; if (regw_o !== 1'b1) begin errors++; $display("[TB] FAIL preflush_regw got %0h want 1", regw_o); end
      stall_i = 1'b1; flush_i = 1'b1;
      drive(1'b1, 32'h1234_5678, 1'b1, 5'd9, {NUM_CH{32'hDEAD_BEEF}});
      tick();
      stall_i = 1'b0; flush_i = 1'b0;
      checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_valid got %0h want 0", valid_o); end
      checks++; if (regw_o !== 1'b0) begin errors++; $display("[TB] FAIL flush_regw got %0h want 0", regw_o); end
      checks++; if (instr_o !== '0) begin errors++; $display("[TB] FAIL flush_instr got %0h want 0", instr_o); end
      checks++; if (rd_o !== '0) begin errors++; $display("[TB] FAIL flush_rd got %0h want 0", rd_o); end
      checks++; if (data_o !== d) begin errors++; $display("[TB] FAIL flush_data got %0h want %0h", data_o, d); end
`ifdef EXMEM_PIPE_STATS_EN
      expBubble++;
      checks++; if (stall_cnt_o !== 4'(expStall)) begin errors++; $display("[TB] FAIL flush_stallcnt got %0d want %0d", stall_cnt_o, expStall); end
      checks++; if (bubble_cnt_o !== 4'(expBubble)) begin errors++; $display("[TB] FAIL flush_bubblecnt got %0d want %0d", bubble_cnt_o, expBubble); end
`endif
   endtask

   task automatic test_bubble();
      logic [NUM_CH*DATA_W-1:0] d;
      d = {32'h8765_4321, 32'h0BAD_F00D, 32'h0000_00FF, 32'hFFFF_0000};
      drive(1'b0, 32'h2007_0001, 1'b1, 5'd7, d);
      tick();
      checks++; if (valid_o !== 1'b0) begin errors++; $display("[TB] FAIL bubble_valid got %0h want 0", valid_o); end
      checks++; if (regw_o !== 1'b0) begin errors++; $display("[TB] FAIL bubble_regw got %0h want 0", regw_o); end
      checks++; if (rd_o !== '0) begin errors++; $display("[TB] FAIL bubble_rd got %0h want 0", rd_o); end
      checks++; if (instr_o !== '0) begin errors++; $display("[TB] FAIL bubble_instr got %0h want 0", instr_o); end
      checks++; if (data_o !== d) begin errors++; $display("[TB] FAIL bubble_data got %0h want %0h", data_o, d); end
`ifdef EXMEM_PIPE_STATS_EN
      expBubble++;
      checks++; if (bubble_cnt_o !== 4'(expBubble)) begin errors++; $display("[TB] FAIL bubble_cnt got %0d want %0d", bubble_cnt_o, expBubble); end
`endif
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'hA000_0000 | i, i[0], 5'(3 * i + 1), {32'(i + 40), 32'(i + 30), 32'(i + 20), 32'(i + 10)});
         tick();
         checks++;
         if (valid_o !== 1'b1 || instr_o !== (32'hA000_0000 | i) || regw_o !== i[0] || rd_o !== 5'(3 * i + 1)
             || data_o !== {32'(i + 40), 32'(i + 30), 32'(i + 20), 32'(i + 10)}) begin
            errors++;
            $display("[TB] FAIL b2b%0d got v%0h i%0h w%0h rd%0h d%0h", i, valid_o, instr_o, regw_o, rd_o, data_o);
         end
      end
   endtask

   task automatic test_stall_saturate_reset();
      stall_i = 1'b1;
      for (int i = 0; i < 20; i++) begin
         drive(1'b1, 32'h5555_0000 + i, 1'b1, 5'd20, {NUM_CH{32'(i)}});
         tick();
      end
      checks++;
      if (valid_o !== 1'b1 || instr_o !== 32'hA000_0003 || regw_o !== 1'b1 || rd_o !== 5'd10) begin
         errors++;
         $display("[TB] FAIL longstall_hold got v%0h i%0h w%0h rd%0h want v1 ia0000003 w1 rda", valid_o, instr_o, regw_o, rd_o);
      end
`ifdef EXMEM_PIPE_STATS_EN
      checks++; if (stall_cnt_o !== 4'd15) begin errors++; $display("[TB] FAIL stallcnt_sat got %0d want 15", stall_cnt_o); end
`endif
      reset = 1'b1; flush_i = 1'b1;
      tick();
      reset = 1'b0; flush_i = 1'b0; stall_i = 1'b0;
      checks++;
      if (valid_o !== 1'b0 || instr_o !== '0 || regw_o !== 1'b0 || rd_o !== '0 || data_o !== '0) begin
         errors++;
         $display("[TB] FAIL reset_midstall got v%0h i%0h w%0h rd%0h d%0h want all 0", valid_o, instr_o, regw_o, rd_o, data_o);
      end
`ifdef EXMEM_PIPE_STATS_EN
      checks++;
      if (stall_cnt_o !== 4'd0 || bubble_cnt_o !== 4'd0) begin
         errors++;
         $display("[TB] FAIL reset_midstall_cnt got s%0d b%0d want 0 0", stall_cnt_o, bubble_cnt_o);
      end
`endif
   endtask

   initial begin
      #1;
      test_reset();
      test_load();
      test_stall();
      test_flush_stall();
      test_bubble();
      test_back_to_back();
      test_stall_saturate_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
